ex_stage: RTL and testbench

Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode stage. It registers the decode-to-execute bundle and evaluates the one-hot ALU operation. It issues the data-SRAM request for loads and stores, and runs an iterative 32-cycle divider that owns the HI/LO registers. Results go to the memory stage and are also fed back to decode for forwarding and load-use stall detection.

---
 rtl/ex_stage_if.sv | 27 ++
 rtl/ex_stage.sv | 237 +++++++++++++++++++++++
 tb/tb_ex_stage.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - decode/execute/memory-side signal bundle for ex_stage
interface ex_stage_if;
    logic [5:0]   stall;           // bit 2 = ID, bit 3 = EX; 1 = Stop
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [75:0]  ex_to_id_bus;
    logic         ex_is_load;
    logic         stallreq_for_ex;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    // upstream/stall-controller side: drives the stage inputs
    modport master (
        output stall, id_to_ex_bus,
        input  ex_to_mem_bus, ex_to_id_bus, ex_is_load, stallreq_for_ex,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );

    // execute stage side
    modport slave (
        input  stall, id_to_ex_bus,
        output ex_to_mem_bus, ex_to_id_bus, ex_is_load, stallreq_for_ex,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ALU, data-SRAM request, iterative divider when EX_DIV_EN is defined
module ex_stage (
    input  logic      clk,
    input  logic      rst,
    ex_stage_if.slave bus
);
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    logic [158:0] id_to_ex_r;

    // decode-to-execute register: reset, bubble, load, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            id_to_ex_r <= '0;
        end else if (bus.stall[2] == STOP && bus.stall[3] == NO_STOP) begin
            id_to_ex_r <= '0;
        end else if (bus.stall[2] == NO_STOP) begin
            id_to_ex_r <= bus.id_to_ex_bus;
        end
    end

    logic [31:0] ex_pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    assign {ex_pc, inst, alu_op, sel_src1, sel_src2, data_ram_en, data_ram_wen,
            rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = id_to_ex_r;

    // rs/rt numbers are already resolved into rdata1/rdata2 by decode
    logic unused_inst_bits;
    assign unused_inst_bits = ^inst[25:16];

    logic is_special;
    logic is_mfhi;
    logic is_mflo;
    logic is_div;
    logic is_divu;
    logic is_div_any;

    assign is_special = (inst[31:26] == 6'b000000);
    assign is_mfhi    = is_special && (inst[5:0] == 6'b010000);
    assign is_mflo    = is_special && (inst[5:0] == 6'b010010);
    assign is_div     = is_special && (inst[5:0] == 6'b011010);
    assign is_divu    = is_special && (inst[5:0] == 6'b011011);
    assign is_div_any = is_div | is_divu;

    logic [31:0] src1;
    logic [31:0] src2;

    // operand selection, first matching select wins
    always_comb begin
        src1 = 32'd0;
        if (sel_src1[0])      src1 = rdata1;
        else if (sel_src1[1]) src1 = ex_pc;
        else if (sel_src1[2]) src1 = {27'd0, inst[10:6]};

        src2 = 32'd0;
        if (sel_src2[0])      src2 = rdata2;
        else if (sel_src2[1]) src2 = {{16{inst[15]}}, inst[15:0]};
        else if (sel_src2[2]) src2 = 32'd8;
        else if (sel_src2[3]) src2 = {16'd0, inst[15:0]};
    end

    logic [31:0] alu_result;

    // one-hot ALU; an all-zero op vector yields zero
    always_comb begin
        alu_result = 32'd0;
        if (alu_op[11])      alu_result = src1 + src2;
        else if (alu_op[10]) alu_result = src1 - src2;
        else if (alu_op[9])  alu_result = {31'd0, $signed(src1) < $signed(src2)};
        else if (alu_op[8])  alu_result = {31'd0, src1 < src2};
        else if (alu_op[7])  alu_result = src1 & src2;
        else if (alu_op[6])  alu_result = ~(src1 | src2);
        else if (alu_op[5])  alu_result = src1 | src2;
        else if (alu_op[4])  alu_result = src1 ^ src2;
        else if (alu_op[3])  alu_result = src2 << src1[4:0];
        else if (alu_op[2])  alu_result = src2 >> src1[4:0];
        else if (alu_op[1])  alu_result = $signed(src2) >>> src1[4:0];
        else if (alu_op[0])  alu_result = {src2[15:0], 16'd0};
    end

    logic [31:0] hi_val;
    logic [31:0] lo_val;

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    div_state_t  div_state;
    div_state_t  div_state_nx;
    logic [4:0]  div_cnt;
    logic        div_done;
    logic [31:0] div_quot;      // shifts out dividend bits, shifts in quotient bits
    logic [31:0] div_rem;
    logic [31:0] div_dsor;
    logic [31:0] div_dividend_raw;
    logic        div_neg_q;
    logic        div_neg_r;
    logic        div_by_zero;
    logic        div_start;
    logic        pipe_advance;
    logic [32:0] div_shift;
    logic [32:0] div_trial;

    // the EX register takes a new bundle or a bubble on this edge
    assign pipe_advance = (bus.stall[2] == NO_STOP) || (bus.stall[3] == NO_STOP);
    assign div_start    = (div_state == DIV_IDLE) && is_div_any && !div_done;
    assign div_shift    = {div_rem, div_quot[31]};
    assign div_trial    = div_shift - {1'b0, div_dsor};

    // divider next-state
    always_comb begin
        div_state_nx = div_state;
        case (div_state)
            DIV_IDLE: if (div_start) div_state_nx = DIV_BUSY;
            DIV_BUSY: if (div_cnt == 5'd31) div_state_nx = DIV_DONE;
            DIV_DONE: div_state_nx = DIV_IDLE;
            default:  div_state_nx = DIV_IDLE;
        endcase
    end

    // divider state register
    always_ff @(posedge clk) begin
        if (rst) div_state <= DIV_IDLE;
        else     div_state <= div_state_nx;
    end

    // operand latch, restoring shift-subtract steps, HI/LO write-back with sign fixup
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt          <= 5'd0;
            div_quot         <= 32'd0;
            div_rem          <= 32'd0;
            div_dsor         <= 32'd0;
            div_dividend_raw <= 32'd0;
            div_neg_q        <= 1'b0;
            div_neg_r        <= 1'b0;
            div_by_zero      <= 1'b0;
            hi_val           <= 32'd0;
            lo_val           <= 32'd0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (div_start) begin
                        div_quot         <= (is_div && rdata1[31]) ? -rdata1 : rdata1;
                        div_dsor         <= (is_div && rdata2[31]) ? -rdata2 : rdata2;
                        div_rem          <= 32'd0;
                        div_cnt          <= 5'd0;
                        div_dividend_raw <= rdata1;
                        div_neg_q        <= is_div && (rdata1[31] ^ rdata2[31]);
                        div_neg_r        <= is_div && rdata1[31];
                        div_by_zero      <= (rdata2 == 32'd0);
                    end
                end
                DIV_BUSY: begin
                    if (!div_trial[32]) begin
                        div_rem  <= div_trial[31:0];
                        div_quot <= {div_quot[30:0], 1'b1};
                    end else begin
                        div_rem  <= div_shift[31:0];
                        div_quot <= {div_quot[30:0], 1'b0};
                    end
                    div_cnt <= div_cnt + 5'd1;
                end
                DIV_DONE: begin
                    if (div_by_zero) begin
                        lo_val <= 32'hFFFF_FFFF;
                        hi_val <= div_dividend_raw;
                    end else begin
                        lo_val <= div_neg_q ? -div_quot : div_quot;
                        hi_val <= div_neg_r ? -div_rem : div_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    // div_done blocks a restart while a foreign stall keeps the finished div in EX
    always_ff @(posedge clk) begin
        if (rst)                         div_done <= 1'b0;
        else if (pipe_advance)           div_done <= 1'b0;
        else if (div_state == DIV_DONE)  div_done <= 1'b1;
    end

    assign bus.stallreq_for_ex = div_start || (div_state == DIV_BUSY);
`else
    assign hi_val              = 32'd0;
    assign lo_val              = 32'd0;
    assign bus.stallreq_for_ex = 1'b0;
`endif

    logic [31:0] ex_result;
    logic        out_rf_we;
    logic [4:0]  out_rf_waddr;

    // HI/LO moves override the ALU result; divides never write the register file
    always_comb begin
        ex_result    = alu_result;
        out_rf_we    = rf_we;
        out_rf_waddr = rf_waddr;
        if (is_mfhi) begin
            ex_result    = hi_val;
            out_rf_we    = 1'b1;
            out_rf_waddr = inst[15:11];
        end else if (is_mflo) begin
            ex_result    = lo_val;
            out_rf_we    = 1'b1;
            out_rf_waddr = inst[15:11];
        end else if (is_div_any) begin
            out_rf_we    = 1'b0;
        end
    end

    logic [75:0] ex_out_bus;

    assign ex_out_bus = {ex_pc, data_ram_en, data_ram_wen, sel_rf_res,
                         out_rf_we, out_rf_waddr, ex_result};

    assign bus.ex_to_mem_bus   = ex_out_bus;
    assign bus.ex_to_id_bus    = ex_out_bus;
    assign bus.ex_is_load      = data_ram_en & sel_rf_res;
    assign bus.data_sram_en    = data_ram_en;
    assign bus.data_sram_wen   = {4{data_ram_en}} & data_ram_wen;
    assign bus.data_sram_addr  = alu_result;
    assign bus.data_sram_wdata = rdata2;
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ex_stage_if bus_if ();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

`ifdef EX_DIV_EN
    localparam int   DIV_CYC = 33;
    localparam logic DIV_ON  = 1'b1;
`else
    localparam int   DIV_CYC = 0;
    localparam logic DIV_ON  = 1'b0;
`endif

    localparam logic [11:0] OP_ADD  = 12'h800;
    localparam logic [11:0] OP_SUB  = 12'h400;
    localparam logic [11:0] OP_SLT  = 12'h200;
    localparam logic [11:0] OP_SLTU = 12'h100;
    localparam logic [11:0] OP_AND  = 12'h080;
    localparam logic [11:0] OP_NOR  = 12'h040;
    localparam logic [11:0] OP_OR   = 12'h020;
    localparam logic [11:0] OP_XOR  = 12'h010;
    localparam logic [11:0] OP_SLL  = 12'h008;
    localparam logic [11:0] OP_SRL  = 12'h004;
    localparam logic [11:0] OP_SRA  = 12'h002;
    localparam logic [11:0] OP_LUI  = 12'h001;
    localparam logic [11:0] OP_NONE = 12'h000;

    localparam logic [2:0] S1_SA = 3'b100;
    localparam logic [2:0] S1_PC = 3'b010;
    localparam logic [2:0] S1_RS = 3'b001;
    localparam logic [2:0] S1_NO = 3'b000;
    localparam logic [3:0] S2_ZEXT = 4'b1000;
    localparam logic [3:0] S2_8    = 4'b0100;
    localparam logic [3:0] S2_SEXT = 4'b0010;
    localparam logic [3:0] S2_RT   = 4'b0001;

    localparam logic [5:0] RUN    = 6'b000000;
    localparam logic [5:0] HOLD   = 6'b001111;
    localparam logic [5:0] BUBBLE = 6'b000111;

    typedef struct packed {
        logic [75:0] bus;
        logic        sram_en;
        logic [3:0]  sram_wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        load;
    } exp_t;

    exp_t        exp_q[$];
    string       tag_q[$];
    logic [31:0] pc = 32'hBFC0_0000;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [158:0] mk(input logic [31:0] ipc, input logic [31:0] inst,
                                        input logic [11:0] op, input logic [2:0] s1,
                                        input logic [3:0] s2, input logic en,
                                        input logic [3:0] wen, input logic we,
                                        input logic [4:0] wa, input logic selres,
                                        input logic [31:0] r1, input logic [31:0] r2);
        return {ipc, inst, op, s1, s2, en, wen, we, wa, selres, r1, r2};
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] ipc, input logic en, input logic [3:0] wen,
                                    input logic selres, input logic we, input logic [4:0] wa,
                                    input logic [31:0] result, input logic [31:0] addr,
                                    input logic [31:0] wdata);
        exp_t e;
        e.bus      = {ipc, en, wen, selres, we, wa, result};
        e.sram_en  = en;
        e.sram_wen = en ? wen : 4'h0;
        e.addr     = addr;
        e.wdata    = wdata;
        e.load     = en & selres;
        return e;
    endfunction

    task automatic compare_out();
        exp_t  e;
        string t;
        check("sb_depth", 128'(exp_q.size()), 128'(1));
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".mem_bus"}, 128'(bus_if.ex_to_mem_bus), 128'(e.bus));
        check({t, ".id_bus"},  128'(bus_if.ex_to_id_bus),  128'(e.bus));
        check({t, ".sram_en"}, 128'(bus_if.data_sram_en),  128'(e.sram_en));
        check({t, ".sram_wen"}, 128'(bus_if.data_sram_wen), 128'(e.sram_wen));
        check({t, ".addr"},    128'(bus_if.data_sram_addr), 128'(e.addr));
        check({t, ".wdata"},   128'(bus_if.data_sram_wdata), 128'(e.wdata));
        check({t, ".is_load"}, 128'(bus_if.ex_is_load),    128'(e.load));
    endtask

    task automatic step(input string tag, input logic [5:0] st, input logic [158:0] b, input exp_t e);
        bus_if.stall        = st;
        bus_if.id_to_ex_bus = b;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        @(negedge clk);
        compare_out();
    endtask

    task automatic send(input string tag, input logic [158:0] b, input exp_t e);
        step(tag, RUN, b, e);
    endtask

    task automatic alu(input string tag, input logic [31:0] inst, input logic [11:0] op,
                       input logic [2:0] s1, input logic [3:0] s2,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] res);
        pc += 32'd4;
        send(tag, mk(pc, inst, op, s1, s2, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, r1, r2),
             mk_exp(pc, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, res, res, r2));
    endtask

    task automatic move_hilo(input string tag, input logic is_hi, input logic [31:0] exp_val);
        logic [31:0] inst;
        inst = {6'd0, 10'd0, 5'd10, 5'd0, (is_hi ? 6'b010000 : 6'b010010)};
        pc += 32'd4;
        send(tag, mk(pc, inst, OP_NONE, S1_NO, 4'h0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0),
             mk_exp(pc, 1'b0, 4'h0, 1'b0, 1'b1, 5'd10, exp_val, 32'd0, 32'd0));
    endtask

    task automatic issue_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] inst;
        inst = {6'd0, 5'd4, 5'd5, 10'd0, (sgn ? 6'b011010 : 6'b011011)};
        pc += 32'd4;
        send(tag, mk(pc, inst, OP_NONE, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0, a, d),
             mk_exp(pc, 1'b0, 4'h0, 1'b0, 1'b0, 5'd9, 32'd0, 32'd0, d));
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi, input logic foreign);
        int cyc;
        issue_div({tag, ".div"}, sgn, a, d);
        cyc = 0;
        while (bus_if.stallreq_for_ex && cyc < 100) begin
            bus_if.stall = HOLD;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check({tag, ".stall_cycles"}, 128'(cyc), 128'(DIV_CYC));
        if (foreign) begin
            for (int i = 0; i < 5; i++) begin
                bus_if.stall = HOLD;
                @(posedge clk);
                @(negedge clk);
                check({tag, ".no_restart"}, 128'(bus_if.stallreq_for_ex), 128'(1'b0));
            end
        end
        move_hilo({tag, ".mflo"}, 1'b0, DIV_ON ? exp_lo : 32'd0);
        move_hilo({tag, ".mfhi"}, 1'b1, DIV_ON ? exp_hi : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        exp_t        held;

        // reset dominates a valid load on the input
        rst                 = 1'b1;
        bus_if.stall        = RUN;
        bus_if.id_to_ex_bus = mk(32'h1234_5678, {6'b100011, 10'd0, 16'h0008}, OP_ADD, S1_RS, S2_SEXT,
                                 1'b1, 4'h0, 1'b1, 5'd9, 1'b1, 32'h100, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.mem_bus",  128'(bus_if.ex_to_mem_bus),  128'(0));
        check("reset.id_bus",   128'(bus_if.ex_to_id_bus),   128'(0));
        check("reset.sram_en",  128'(bus_if.data_sram_en),   128'(0));
        check("reset.sram_wen", 128'(bus_if.data_sram_wen),  128'(0));
        check("reset.addr",     128'(bus_if.data_sram_addr), 128'(0));
        check("reset.wdata",    128'(bus_if.data_sram_wdata), 128'(0));
        check("reset.is_load",  128'(bus_if.ex_is_load),     128'(0));
        check("reset.stallreq", 128'(bus_if.stallreq_for_ex), 128'(0));
        rst = 1'b0;

        // addiu 5 + sext(0xFFFF)
        alu("addiu", {6'b001001, 10'd0, 16'hFFFF}, OP_ADD, S1_RS, S2_SEXT, 32'd5, 32'h1234, 32'd4);

        // lw from 0x100 + 8
        pc += 32'd4;
        send("lw", mk(pc, {6'b100011, 10'd0, 16'h0008}, OP_ADD, S1_RS, S2_SEXT,
                      1'b1, 4'h0, 1'b1, 5'd9, 1'b1, 32'h100, 32'd0),
             mk_exp(pc, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h108, 32'h108, 32'd0));

        // sw to 0x200 - 4
        pc += 32'd4;
        send("sw", mk(pc, {6'b101011, 10'd0, 16'hFFFC}, OP_ADD, S1_RS, S2_SEXT,
                      1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h200, 32'hDEAD_BEEF),
             mk_exp(pc, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h1FC, 32'h1FC, 32'hDEAD_BEEF));

        // byte enables are masked off when the RAM is not enabled
        pc += 32'd4;
        send("wen_mask", mk(pc, {6'd0, 20'd0, 6'b100001}, OP_ADD, S1_RS, S2_RT,
                            1'b0, 4'hF, 1'b1, 5'd7, 1'b0, 32'd1, 32'd2),
             mk_exp(pc, 1'b0, 4'hF, 1'b0, 1'b1, 5'd7, 32'd3, 32'd3, 32'd2));

        alu("sub",    {6'd0, 20'd0, 6'b100011}, OP_SUB,  S1_RS, S2_RT, 32'd3, 32'd5, 32'hFFFF_FFFE);
        alu("slt",    {6'd0, 20'd0, 6'b101010}, OP_SLT,  S1_RS, S2_RT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu("sltu",   {6'd0, 20'd0, 6'b101011}, OP_SLTU, S1_RS, S2_RT, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu("slt_min", {6'd0, 20'd0, 6'b101010}, OP_SLT, S1_RS, S2_RT, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1);
        alu("and",    {6'd0, 20'd0, 6'b100100}, OP_AND,  S1_RS, S2_RT, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        alu("or",     {6'd0, 20'd0, 6'b100101}, OP_OR,   S1_RS, S2_RT, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34);
        alu("xor",    {6'd0, 20'd0, 6'b100110}, OP_XOR,  S1_RS, S2_RT, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34);
        alu("nor",    {6'd0, 20'd0, 6'b100111}, OP_NOR,  S1_RS, S2_RT, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h000F_00CB);
        alu("sll",    {6'd0, 15'd0, 5'd4, 6'b000000}, OP_SLL, S1_SA, S2_RT, 32'hFFFF_FFFF, 32'd1, 32'h10);
        alu("srl",    {6'd0, 15'd0, 5'd4, 6'b000010}, OP_SRL, S1_SA, S2_RT, 32'd0, 32'h8000_0000, 32'h0800_0000);
        alu("sra",    {6'd0, 15'd0, 5'd4, 6'b000011}, OP_SRA, S1_SA, S2_RT, 32'd0, 32'h8000_0000, 32'hF800_0000);
        alu("sllv",   {6'd0, 20'd0, 6'b000100}, OP_SLL,  S1_RS, S2_RT, 32'h21, 32'd3, 32'd6);
        alu("lui",    {6'b001111, 10'd0, 16'h1234}, OP_LUI, S1_NO, S2_ZEXT, 32'd0, 32'd0, 32'h1234_0000);
        alu("ori",    {6'b001101, 10'd0, 16'h8001}, OP_OR, S1_RS, S2_ZEXT, 32'h0001_0000, 32'd0, 32'h0001_8001);
        alu("no_op",  {6'd0, 20'd0, 6'b100001}, OP_NONE, S1_RS, S2_RT, 32'd5, 32'd6, 32'd0);

        // return-address computation pc + 8
        pc += 32'd4;
        send("jal", mk(pc, {6'b000011, 26'd0}, OP_ADD, S1_PC, S2_8, 1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'd0, 32'd0),
             mk_exp(pc, 1'b0, 4'h0, 1'b0, 1'b1, 5'd31, pc + 32'd8, pc + 32'd8, 32'd0));

        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            alu("rand_sub", {6'd0, 20'd0, 6'b100011}, OP_SUB, S1_RS, S2_RT, a, b, a - b);
        end

        // hold keeps the current bundle, bubble clears it
        pc += 32'd4;
        held = mk_exp(pc, 1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'd4, 32'd4, 32'd0);
        send("pre_hold", mk(pc, {6'b100011, 10'd0, 16'hFFFF}, OP_ADD, S1_RS, S2_SEXT,
                            1'b1, 4'h0, 1'b1, 5'd12, 1'b1, 32'd5, 32'd0), held);
        step("hold", HOLD, mk(32'h0BAD_0000, {6'b001001, 26'd1}, OP_XOR, S1_RS, S2_RT,
                              1'b1, 4'hF, 1'b1, 5'd1, 1'b0, 32'd7, 32'd9), held);
        step("bubble", BUBBLE, mk(32'h0BAD_0000, {6'b001001, 26'd1}, OP_XOR, S1_RS, S2_RT,
                                  1'b1, 4'hF, 1'b1, 5'd1, 1'b0, 32'd7, 32'd9),
             mk_exp(32'd0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0));

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_div("div_5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1);

        // reset in the middle of a divide
        issue_div("rst_div", 1'b0, 32'd1000, 32'd3);
        for (int i = 0; i < 11; i++) begin
            bus_if.stall = HOLD;
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_div.busy", 128'(bus_if.stallreq_for_ex), 128'(DIV_ON));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_div.stallreq", 128'(bus_if.stallreq_for_ex), 128'(0));
        check("rst_div.mem_bus", 128'(bus_if.ex_to_mem_bus), 128'(0));
        move_hilo("rst_div.mflo", 1'b0, 32'd0);
        move_hilo("rst_div.mfhi", 1'b1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
